decode_issue_stage: RTL and testbench

- Parametrised decode front-end between fetch and execute.
- Buffers fetched instructions in a DEPTH-entry FIFO and extracts rs1/rs2/rd per RV64I format.
- Tracks in-flight destination registers with per-register latency counters and holds issue while a source is not yet forwardable.
- Supports a pipeline flush on taken jump/branch and counts hazard-stall cycles for performance monitoring.

---
 rtl/decode_pkg.sv | 53 +++++
 rtl/decode_issue_stage_scoreboard.sv | 56 +++++
 rtl/decode_issue_stage.sv | 142 ++++++++++++++
 tb/tb_decode_issue_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Shared RV64I opcodes, FIFO entry type and field-usage helpers
//               for the decode/issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;

    // Entry widths match the stage defaults; the top casts to/from its own widths.
    localparam int c_ENTRY_XLEN = 64;
    localparam int c_ENTRY_ILEN = 32;

    typedef struct packed {
        logic [c_ENTRY_ILEN-1:0] instruction;
        logic [c_ENTRY_XLEN-1:0] PC;
    } fifo_entry_t;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        case (opcode)
            OP, OP_32, OP_IMM, OP_IMM_32, LOAD, STORE, BRANCH, JALR: uses_rs1 = 1'b1;
            default:                                                 uses_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        case (opcode)
            OP, OP_32, STORE, BRANCH: uses_rs2 = 1'b1;
            default:                  uses_rs2 = 1'b0;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [6:0] opcode);
        case (opcode)
            OP, OP_32, OP_IMM, OP_IMM_32, LOAD, LUI, AUIPC, JAL, JALR: writes_rd = 1'b1;
            default:                                                   writes_rd = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_issue_stage_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register latency counters; flags sources whose producer
//               result is not yet forwardable.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int REGISTER_SIZE = 5,
    parameter int LAT_SIZE      = 2,
    parameter int ALU_LATENCY   = 1,
    parameter int LOAD_LATENCY  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REGISTER_SIZE-1:0] i_rs1,
    input  logic                     i_rs1_used,
    input  logic [REGISTER_SIZE-1:0] i_rs2,
    input  logic                     i_rs2_used,
    input  logic                     i_set,
    input  logic [REGISTER_SIZE-1:0] i_rd,
    input  logic                     i_is_load,
    output logic                     o_hazard
);

    localparam int                  c_NUM_REGS = 2 ** REGISTER_SIZE;
    localparam logic [LAT_SIZE-1:0] c_ALU_LAT  = LAT_SIZE'(ALU_LATENCY);
    localparam logic [LAT_SIZE-1:0] c_LOAD_LAT = LAT_SIZE'(LOAD_LATENCY);

    logic [LAT_SIZE-1:0] r_sb [c_NUM_REGS];
    logic                w_rs1_busy;
    logic                w_rs2_busy;

    // A fresh load of a counter takes priority over its decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_sb[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                if (i_set && (i_rd != '0) && (i_rd == REGISTER_SIZE'(i))) begin
                    r_sb[i] <= i_is_load ? c_LOAD_LAT : c_ALU_LAT;
                end else if (r_sb[i] != '0) begin
                    r_sb[i] <= r_sb[i] - 1'b1;
                end
            end
        end
    end

    assign w_rs1_busy = i_rs1_used && (i_rs1 != '0) && (r_sb[i_rs1] != '0);
    assign w_rs2_busy = i_rs2_used && (i_rs2 != '0) && (r_sb[i_rs2] != '0);
    assign o_hazard   = w_rs1_busy || w_rs2_busy;

endmodule
`default_nettype wire

// File: rtl/decode_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_issue_stage
// Description : Instruction FIFO, RV64I register-field decode and scoreboard
//               gated issue with flush and hazard-stall counting.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_issue_stage
    import decode_pkg::*;
#(
    parameter int XLEN               = 64,
    parameter int INSTRUCTION_LENGTH = XLEN / 2,
    parameter int REGISTER_SIZE      = 5,
    parameter int DEPTH              = 4,
    parameter int LAT_SIZE           = 2,
    parameter int ALU_LATENCY        = 1,
    parameter int LOAD_LATENCY       = 2,
    parameter int STALL_CNT_SIZE     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INSTRUCTION_LENGTH-1:0] in_instruction,
    input  logic [XLEN-1:0]               in_PC,
    input  logic                          flush,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    output logic [INSTRUCTION_LENGTH-1:0] issue_instruction,
    output logic [XLEN-1:0]               issue_PC,
    output logic [REGISTER_SIZE-1:0]      issue_rs1,
    output logic [REGISTER_SIZE-1:0]      issue_rs2,
    output logic [REGISTER_SIZE-1:0]      issue_rd,
    output logic                          issue_is_load,
    output logic [$clog2(DEPTH):0]        occupancy,
    output logic                          hazard_stall,
    output logic [STALL_CNT_SIZE-1:0]     stall_cycles
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    fifo_entry_t               r_mem [DEPTH];
    logic [c_PTR_W-1:0]        r_wr_ptr;
    logic [c_PTR_W-1:0]        r_rd_ptr;
    logic [c_CNT_W-1:0]        r_count;
    logic [STALL_CNT_SIZE-1:0] r_stall_cnt;

    fifo_entry_t                   w_head;
    fifo_entry_t                   w_push_entry;
    logic [INSTRUCTION_LENGTH-1:0] w_instr;
    logic [6:0]                    w_opcode;
    logic                          w_head_valid;
    logic                          w_rs1_used;
    logic                          w_rs2_used;
    logic                          w_hazard;
    logic                          w_push;
    logic                          w_pop;

    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_valid = (r_count != '0);
    assign w_instr      = INSTRUCTION_LENGTH'(w_head.instruction);
    assign w_opcode     = w_instr[6:0];
    assign w_rs1_used   = uses_rs1(w_opcode);
    assign w_rs2_used   = uses_rs2(w_opcode);

    assign w_push_entry.instruction = c_ENTRY_ILEN'(in_instruction);
    assign w_push_entry.PC          = c_ENTRY_XLEN'(in_PC);

    assign issue_instruction = w_instr;
    assign issue_PC          = XLEN'(w_head.PC);
    assign issue_rs1         = w_rs1_used ? w_instr[15 +: REGISTER_SIZE] : '0;
    assign issue_rs2         = w_rs2_used ? w_instr[20 +: REGISTER_SIZE] : '0;
    assign issue_rd          = writes_rd(w_opcode) ? w_instr[7 +: REGISTER_SIZE] : '0;
    assign issue_is_load     = (w_opcode == LOAD);

    assign in_ready     = (r_count != c_CNT_W'(DEPTH));
    assign occupancy    = r_count;
    assign hazard_stall = w_head_valid && w_hazard;
    assign issue_valid  = !rst && w_head_valid && !w_hazard && !flush;
    assign stall_cycles = r_stall_cnt;

    // A flushed cycle neither accepts the new instruction nor retires the head.
    assign w_push = in_valid && in_ready && !flush;
    assign w_pop  = issue_valid && issue_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_push_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (hazard_stall && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    reg_scoreboard #(
        .REGISTER_SIZE (REGISTER_SIZE),
        .LAT_SIZE      (LAT_SIZE),
        .ALU_LATENCY   (ALU_LATENCY),
        .LOAD_LATENCY  (LOAD_LATENCY)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_rs1      (issue_rs1),
        .i_rs1_used (w_rs1_used),
        .i_rs2      (issue_rs2),
        .i_rs2_used (w_rs2_used),
        .i_set      (w_pop),
        .i_rd       (issue_rd),
        .i_is_load  (issue_is_load),
        .o_hazard   (w_hazard)
    );

endmodule
`default_nettype wire

// File: tb/tb_decode_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_issue_stage
// Description : Directed bench for decode_issue_stage; a second instance with
//               LOAD_LATENCY=3 exposes scoreboard state across flush/reset.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_decode_issue_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, issue_ready;
    logic [31:0] in_instruction;
    logic [63:0] in_PC;

    logic        in_ready, issue_valid, issue_is_load, hazard_stall;
    logic [31:0] issue_instruction, stall_cycles;
    logic [63:0] issue_PC;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic [2:0]  occupancy;

    logic        l3_in_ready, l3_issue_valid, l3_issue_is_load, l3_hazard_stall;
    logic [31:0] l3_issue_instruction, l3_stall_cycles;
    logic [63:0] l3_issue_PC;
    logic [4:0]  l3_issue_rs1, l3_issue_rs2, l3_issue_rd;
    logic [2:0]  l3_occupancy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_issue_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_PC(in_PC), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_instruction(issue_instruction), .issue_PC(issue_PC),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .issue_is_load(issue_is_load), .occupancy(occupancy),
        .hazard_stall(hazard_stall), .stall_cycles(stall_cycles)
    );

    decode_issue_stage #(.LOAD_LATENCY(3)) dut_l3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l3_in_ready),
        .in_instruction(in_instruction), .in_PC(in_PC), .flush(flush),
        .issue_valid(l3_issue_valid), .issue_ready(issue_ready),
        .issue_instruction(l3_issue_instruction), .issue_PC(l3_issue_PC),
        .issue_rs1(l3_issue_rs1), .issue_rs2(l3_issue_rs2), .issue_rd(l3_issue_rd),
        .issue_is_load(l3_issue_is_load), .occupancy(l3_occupancy),
        .hazard_stall(l3_hazard_stall), .stall_cycles(l3_stall_cycles)
    );

    function automatic logic [31:0] enc_add(input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_ld(input int rd, input int rs1);
        return {12'b0, 5'(rs1), 3'b011, 5'(rd), 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_lui(input int rd, input int imm20);
        return {20'(imm20), 5'(rd), 7'b0110111};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [63:0] pc);
        in_valid       = 1'b1;
        in_instruction = instr;
        in_PC          = pc;
        tick();
        in_valid       = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; issue_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL rst_occupancy got %0d want 0", occupancy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        n_cmp++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL rst_issue_valid got %b want 0", issue_valid); end
        n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL rst_hazard got %b want 0", hazard_stall); end
        n_cmp++; if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL rst_stall_cycles got %0d want 0", stall_cycles); end
        n_cmp++; if (issue_instruction !== 32'd0) begin n_err++; $display("FAIL rst_instr got %h want 0", issue_instruction); end
        n_cmp++; if (issue_PC !== 64'd0) begin n_err++; $display("FAIL rst_pc got %h want 0", issue_PC); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_instruction = enc_addi(11 + i, 0, i); in_PC = 64'(i * 4);
            #1;
            n_cmp++; if (in_ready !== (i < 4)) begin n_err++; $display("FAIL fd_in_ready[%0d] got %b want %b", i, in_ready, (i < 4)); end
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL fd_full_occ got %0d want 4", occupancy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fd_full_ready got %b want 0", in_ready); end
        issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (issue_valid !== 1'b1) begin n_err++; $display("FAIL fd_issue_valid[%0d] got %b want 1", k, issue_valid); end
            n_cmp++; if (issue_PC !== 64'(k * 4)) begin n_err++; $display("FAIL fd_issue_pc[%0d] got %h want %h", k, issue_PC, k * 4); end
            n_cmp++; if (issue_rd !== 5'(11 + k)) begin n_err++; $display("FAIL fd_issue_rd[%0d] got %0d want %0d", k, issue_rd, 11 + k); end
            tick();
        end
        #1;
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL fd_drain_occ got %0d want 0", occupancy); end
        n_cmp++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL fd_drain_valid got %b want 0", issue_valid); end
    endtask

    task automatic test_raw_alu();
        do_reset();
        push(enc_add(5, 1, 2), 64'h100);
        push(enc_add(6, 5, 3), 64'h104);
        issue_ready = 1'b1;
        #1;
        n_cmp++; if (issue_valid !== 1'b1 || issue_PC !== 64'h100) begin n_err++; $display("FAIL raw_first got v=%b pc=%h want v=1 pc=100", issue_valid, issue_PC); end
        tick(); #1;
        n_cmp++; if (hazard_stall !== 1'b1 || issue_valid !== 1'b0) begin n_err++; $display("FAIL raw_stall got hs=%b v=%b want hs=1 v=0", hazard_stall, issue_valid); end
        tick(); #1;
        n_cmp++; if (issue_valid !== 1'b1 || issue_PC !== 64'h104) begin n_err++; $display("FAIL raw_second got v=%b pc=%h want v=1 pc=104", issue_valid, issue_PC); end
        n_cmp++; if (stall_cycles !== 32'd1) begin n_err++; $display("FAIL raw_stall_cycles got %0d want 1", stall_cycles); end
    endtask

    task automatic test_load_use();
        do_reset();
        push(enc_ld(7, 1), 64'h200);
        push(enc_add(8, 7, 7), 64'h204);
        issue_ready = 1'b1;
        #1;
        n_cmp++; if (issue_valid !== 1'b1 || issue_is_load !== 1'b1) begin n_err++; $display("FAIL lu_load got v=%b ld=%b want v=1 ld=1", issue_valid, issue_is_load); end
        n_cmp++; if (issue_rd !== 5'd7 || issue_rs1 !== 5'd1 || issue_rs2 !== 5'd0) begin n_err++; $display("FAIL lu_fields got rd=%0d rs1=%0d rs2=%0d want 7 1 0", issue_rd, issue_rs1, issue_rs2); end
        for (int s = 0; s < 2; s++) begin
            tick(); #1;
            n_cmp++; if (hazard_stall !== 1'b1 || issue_valid !== 1'b0) begin n_err++; $display("FAIL lu_stall[%0d] got hs=%b v=%b want hs=1 v=0", s, hazard_stall, issue_valid); end
        end
        tick(); #1;
        n_cmp++; if (issue_valid !== 1'b1 || issue_PC !== 64'h204 || issue_is_load !== 1'b0) begin n_err++; $display("FAIL lu_use got v=%b pc=%h ld=%b want v=1 pc=204 ld=0", issue_valid, issue_PC, issue_is_load); end
        n_cmp++; if (stall_cycles !== 32'd2) begin n_err++; $display("FAIL lu_stall_cycles got %0d want 2", stall_cycles); end
    endtask

    task automatic test_x0_fields();
        do_reset();
        push(enc_addi(0, 0, 1), 64'h300);
        push(enc_add(9, 0, 0), 64'h304);
        push(enc_lui(10, 20'h12345), 64'h308);
        issue_ready = 1'b1;
        #1;
        n_cmp++; if (issue_valid !== 1'b1 || issue_rd !== 5'd0) begin n_err++; $display("FAIL x0_addi got v=%b rd=%0d want v=1 rd=0", issue_valid, issue_rd); end
        tick(); #1;
        n_cmp++; if (issue_valid !== 1'b1 || hazard_stall !== 1'b0 || issue_rd !== 5'd9) begin n_err++; $display("FAIL x0_add got v=%b hs=%b rd=%0d want v=1 hs=0 rd=9", issue_valid, hazard_stall, issue_rd); end
        tick(); #1;
        n_cmp++; if (issue_instruction !== 32'h12345537 || issue_valid !== 1'b1) begin n_err++; $display("FAIL x0_lui_instr got %h v=%b want 12345537 v=1", issue_instruction, issue_valid); end
        n_cmp++; if (issue_rs1 !== 5'd0 || issue_rs2 !== 5'd0 || issue_rd !== 5'd10) begin n_err++; $display("FAIL x0_lui_fields got rs1=%0d rs2=%0d rd=%0d want 0 0 10", issue_rs1, issue_rs2, issue_rd); end
        n_cmp++; if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL x0_stall_cycles got %0d want 0", stall_cycles); end
    endtask

    task automatic test_flush();
        do_reset();
        push(enc_ld(7, 1), 64'h400);
        push(enc_addi(20, 0, 1), 64'h404);
        push(enc_addi(21, 0, 2), 64'h408);
        push(enc_addi(22, 0, 3), 64'h40C);
        issue_ready = 1'b1;
        #1;
        n_cmp++; if (issue_valid !== 1'b1 || issue_is_load !== 1'b1) begin n_err++; $display("FAIL fl_ld_issue got v=%b ld=%b want 1 1", issue_valid, issue_is_load); end
        tick();
        flush = 1'b1; in_valid = 1'b1; in_instruction = enc_addi(23, 0, 4); in_PC = 64'h500;
        #1;
        n_cmp++; if (occupancy !== 3'd3 || issue_valid !== 1'b0) begin n_err++; $display("FAIL fl_during got occ=%0d v=%b want occ=3 v=0", occupancy, issue_valid); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++; if (occupancy !== 3'd0 || issue_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL fl_after got occ=%0d v=%b rdy=%b want 0 0 1", occupancy, issue_valid, in_ready); end
        push(enc_add(8, 7, 0), 64'h600);
        #1;
        n_cmp++; if (issue_valid !== 1'b1 || issue_PC !== 64'h600) begin n_err++; $display("FAIL fl_main_issue got v=%b pc=%h want v=1 pc=600", issue_valid, issue_PC); end
        n_cmp++; if (l3_hazard_stall !== 1'b1 || l3_issue_valid !== 1'b0) begin n_err++; $display("FAIL fl_inflight_stall got hs=%b v=%b want hs=1 v=0", l3_hazard_stall, l3_issue_valid); end
        tick(); #1;
        n_cmp++; if (l3_issue_valid !== 1'b1 || l3_issue_PC !== 64'h600) begin n_err++; $display("FAIL fl_inflight_issue got v=%b pc=%h want v=1 pc=600", l3_issue_valid, l3_issue_PC); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        push(enc_ld(7, 1), 64'h700);
        push(enc_add(8, 7, 7), 64'h704);
        push(enc_addi(9, 0, 1), 64'h708);
        issue_ready = 1'b1;
        tick(); #1;
        n_cmp++; if (hazard_stall !== 1'b1 || occupancy !== 3'd2) begin n_err++; $display("FAIL rm_pre got hs=%b occ=%0d want hs=1 occ=2", hazard_stall, occupancy); end
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b1; in_instruction = enc_add(8, 7, 7); in_PC = 64'h800;
        #1;
        n_cmp++; if (occupancy !== 3'd0 || stall_cycles !== 32'd0) begin n_err++; $display("FAIL rm_cleared got occ=%0d sc=%0d want 0 0", occupancy, stall_cycles); end
        n_cmp++; if (issue_PC !== 64'd0 || issue_instruction !== 32'd0 || issue_valid !== 1'b0) begin n_err++; $display("FAIL rm_head got pc=%h in=%h v=%b want 0 0 0", issue_PC, issue_instruction, issue_valid); end
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++; if (issue_valid !== 1'b1 || hazard_stall !== 1'b0 || issue_PC !== 64'h800) begin n_err++; $display("FAIL rm_dep_issue got v=%b hs=%b pc=%h want 1 0 800", issue_valid, hazard_stall, issue_PC); end
        n_cmp++; if (l3_issue_valid !== 1'b1 || l3_hazard_stall !== 1'b0) begin n_err++; $display("FAIL rm_sb_cleared got v=%b hs=%b want 1 0", l3_issue_valid, l3_hazard_stall); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; issue_ready = 1'b0;
        in_instruction = '0; in_PC = '0;
        test_reset();
        test_fill_drain();
        test_raw_alu();
        test_load_use();
        test_x0_fields();
        test_flush();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
